// File: rtl/calc_host_pkg.sv
// Command-byte bit constants for the calculator device, the request opcode
// type and the host sequencer states shared by the host and its sub-blocks.
package cmd_bits;

  // Bit positions of the device command byte.
  localparam int b_op_2   = 0;
  localparam int b_addop  = 1;
  localparam int b_subop  = 2;
  localparam int b_addres = 3;
  localparam int b_subres = 4;
  localparam int b_tx     = 5;

  localparam int CMD_W = 8;

  typedef enum logic [2:0] {
    OP_NONE    = 3'd0,
    OP_ADD     = 3'd1,
    OP_SUB     = 3'd2,
    OP_ACC_ADD = 3'd3,
    OP_ACC_SUB = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD2,
    S_DAT2,
    S_CMD1,
    S_DAT1,
    S_CMD_RD,
    S_WAIT_DRDY,
    S_DONE
  } state_e;

  // Second-operand load command and result read-back command.
  localparam logic [CMD_W-1:0] CMD_OP2 = CMD_W'(1) << b_op_2;
  localparam logic [CMD_W-1:0] CMD_RD  = CMD_W'(1) << b_tx;

  // ALU command byte for an opcode; zero for anything that is not an ALU op.
  function automatic logic [CMD_W-1:0] op_to_cmd(op_e op);
    logic [CMD_W-1:0] cmd;
    cmd = '0;
    case (op)
      OP_ADD:     cmd[b_addop]  = 1'b1;
      OP_SUB:     cmd[b_subop]  = 1'b1;
      OP_ACC_ADD: cmd[b_addres] = 1'b1;
      OP_ACC_SUB: cmd[b_subres] = 1'b1;
      default:    cmd = '0;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/calc_host_tmo.sv
// Stall timer: counts cycles spent waiting on the device and flags expiry
// once TMO-1 is reached. Clear has priority and restarts the count at zero.
module calc_host_tmo #(
  parameter int TMO = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;

  logic [CW-1:0] count;

  assign expired = (count == CW'(TMO - 1));

  // Cycle counter, saturating at the expiry value.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values of its peers, independent of block order.
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/calc_host.sv
// Bus initiator for the calculator device: turns one valid/ready arithmetic
// request into the device command/operand byte sequence, optionally reads
// the result back, and reports completion with a one-cycle response pulse.
module calc_host
  import cmd_bits::*;
#(
  parameter int DW  = 8,
  parameter int TMO = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_op,
  input  logic [DW-1:0] req_a,
  input  logic [DW-1:0] req_b,
  input  logic          req_rd,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          dev_cs,
  output logic [DW-1:0] dev_din,
  input  logic          dev_busy,
  input  logic          dev_drdy,
  input  logic [DW-1:0] dev_dout
);

  state_e        state, state_nxt;
  op_e           op_q;
  logic [DW-1:0] a_q, b_q;
  logic          rd_q;
  logic          accept, capture, abort;
  logic          expired, waiting;

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_DONE);
  assign waiting   = (state == S_CMD2) || (state == S_CMD1) ||
                     (state == S_CMD_RD) || (state == S_WAIT_DRDY);

  calc_host_tmo #(.TMO(TMO)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_nxt != state),
    .enable  (waiting),
    .expired (expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next state and device outputs; command bytes go out only when the
  // device is idle, and an expired wait aborts straight to DONE.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_nxt = state;
    dev_cs    = 1'b0;
    dev_din   = '0;
    accept    = 1'b0;
    capture   = 1'b0;
    abort     = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          case (op_e'(req_op))
            OP_ADD, OP_SUB:         state_nxt = S_CMD2;
            OP_ACC_ADD, OP_ACC_SUB: state_nxt = S_CMD1;
            default:                state_nxt = req_rd ? S_CMD_RD : S_DONE;
          endcase
        end
      end
      S_CMD2: begin
        if (!dev_busy) begin
          dev_cs    = 1'b1;
          dev_din   = DW'(CMD_OP2);
          state_nxt = S_DAT2;
        end else if (expired) begin
          abort     = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DAT2: begin
        dev_din   = b_q;
        state_nxt = S_CMD1;
      end
      S_CMD1: begin
        if (!dev_busy) begin
          dev_cs    = 1'b1;
          dev_din   = DW'(op_to_cmd(op_q));
          state_nxt = S_DAT1;
        end else if (expired) begin
          abort     = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DAT1: begin
        dev_din   = a_q;
        state_nxt = rd_q ? S_CMD_RD : S_DONE;
      end
      S_CMD_RD: begin
        if (!dev_busy) begin
          dev_cs    = 1'b1;
          dev_din   = DW'(CMD_RD);
          state_nxt = S_WAIT_DRDY;
        end else if (expired) begin
          abort     = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_WAIT_DRDY: begin
        if (dev_drdy) begin
          capture   = 1'b1;
          state_nxt = S_DONE;
        end else if (expired) begin
          abort     = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request latch and response registers; a new request clears the old
  // response so a no-read or aborted request reports zero data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q     <= OP_NONE;
      a_q      <= '0;
      b_q      <= '0;
      rd_q     <= 1'b0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else if (accept) begin
      op_q     <= op_e'(req_op);
      a_q      <= req_a;
      b_q      <= req_b;
      rd_q     <= req_rd;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else if (capture) begin
      rsp_data <= dev_dout;
    end else if (abort) begin
      rsp_data <= '0;
      rsp_err  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_calc_host.sv
// Directed bench for calc_host against a small calculator device model.
`timescale 1ns/1ps
module tb_calc_host;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_op = 3'd0;
  logic [7:0] req_a = 8'd0;
  logic [7:0] req_b = 8'd0;
  logic       req_rd = 1'b0;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       dev_cs;
  logic [7:0] dev_din;
  logic       dev_busy;
  logic       dev_drdy;
  logic [7:0] dev_dout;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  calc_host #(.DW(8), .TMO(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_rd    (req_rd),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .dev_cs    (dev_cs),
    .dev_din   (dev_din),
    .dev_busy  (dev_busy),
    .dev_drdy  (dev_drdy),
    .dev_dout  (dev_dout)
  );

  // ---------------- device model ----------------
  // Command bytes: OP2=0x01, ADD=0x02, SUB=0x04, ACC_ADD=0x08, ACC_SUB=0x10, RD=0x20.
  logic [1:0] d_phase;   // 0 command, 1 expecting b, 2 expecting a
  logic [7:0] d_cmd, d_b, d_result;
  logic       d_busy;
  logic       force_busy = 1'b0;
  logic       mute_drdy  = 1'b0;

  assign dev_busy = d_busy | force_busy;

  initial d_result = 8'd0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_phase  <= 2'd0;
      d_cmd    <= 8'd0;
      d_b      <= 8'd0;
      d_busy   <= 1'b0;
      dev_drdy <= 1'b0;
      dev_dout <= 8'd0;
    end else begin
      d_busy   <= 1'b0;
      dev_drdy <= 1'b0;
      case (d_phase)
        2'd1: begin d_b <= dev_din; d_phase <= 2'd0; end
        2'd2: begin
          case (d_cmd)
            8'h02: d_result <= dev_din + d_b;
            8'h04: d_result <= dev_din - d_b;
            8'h08: d_result <= d_result + dev_din;
            8'h10: d_result <= d_result - dev_din;
            default: d_result <= d_result;
          endcase
          d_busy  <= 1'b1;   // process cycle
          d_phase <= 2'd0;
        end
        default: begin
          if (dev_cs) begin
            if (dev_din == 8'h01) d_phase <= 2'd1;
            else if (dev_din == 8'h20) begin
              dev_drdy <= ~mute_drdy;
              dev_dout <= d_result;
            end else begin
              d_cmd   <= dev_din;
              d_phase <= 2'd2;
            end
          end
        end
      endcase
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-request log, cycle 0 = accept cycle.
  logic [63:0] cs_mask;
  logic [7:0]  din_log [0:63];
  int          rsp_cyc;
  logic [7:0]  got_data;
  logic        got_err;
  logic        ready_after;

  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic rd, input int busy_n);
    int n;
    cs_mask = '0;
    rsp_cyc = -1;
    for (int i = 0; i < 64; i++) din_log[i] = 8'h00;
    @(negedge clk);
    req_valid  = 1'b1;
    req_op     = op;
    req_a      = a;
    req_b      = b;
    req_rd     = rd;
    force_busy = (busy_n > 0);
    n = 0;
    while (rsp_cyc < 0 && n < 60) begin
      @(negedge clk);
      n++;
      req_valid  = 1'b0;
      force_busy = (n < busy_n);
      #1;
      cs_mask[n] = dev_cs;
      din_log[n] = dev_din;
      if (rsp_valid) begin
        rsp_cyc  = n;
        got_data = rsp_data;
        got_err  = rsp_err;
      end
    end
    if (rsp_cyc < 0) check("rsp_never_seen", 64'd0, 64'd1);
    @(negedge clk);
    #1;
    ready_after = req_ready;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs",
          {56'd0, req_ready, rsp_valid, rsp_err, dev_cs, 4'd0},
          {56'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
    check("reset_data", {rsp_data, dev_din}, 16'h0000);
    rst = 1'b1;

    // ADD 5+3 with read
    issue(3'd1, 8'd5, 8'd3, 1'b1, 0);
    check("add_rsp_cycle", 64'(rsp_cyc), 64'd8);
    check("add_data", {got_err, got_data}, {1'b0, 8'h08});
    check("add_cs_cycles", cs_mask, 64'h4A);
    check("add_din_seq", {din_log[1], din_log[2], din_log[3], din_log[4], din_log[6]},
          40'h01_03_02_05_20);
    check("add_ready_after", 64'(ready_after), 64'd1);

    // SUB 2-7 wraps
    issue(3'd2, 8'd2, 8'd7, 1'b1, 0);
    check("sub_data", {got_err, got_data}, {1'b0, 8'hFB});
    check("sub_din_cmd", 64'(din_log[3]), 64'h04);

    // ACC_ADD 10: 0xFB+0x0A = 0x05
    issue(3'd3, 8'd10, 8'd0, 1'b1, 0);
    check("accadd_rsp_cycle", 64'(rsp_cyc), 64'd6);
    check("accadd_data", 64'(got_data), 64'h05);
    check("accadd_cs_cycles", cs_mask, 64'h12);
    check("accadd_din_cmd", {din_log[1], din_log[2]}, 16'h08_0A);

    // ACC_SUB 1: 0x05-1 = 0x04
    issue(3'd4, 8'd1, 8'd0, 1'b1, 0);
    check("accsub_data", {rsp_cyc[7:0], got_data}, {8'd6, 8'h04});
    check("accsub_din_cmd", 64'(din_log[1]), 64'h10);

    // NONE without read
    issue(3'd0, 8'd0, 8'd0, 1'b0, 0);
    check("none_rsp_cycle", 64'(rsp_cyc), 64'd1);
    check("none_data_cs", {cs_mask, got_data}, 72'd0);

    // ADD 4+4 without read: data 0, device result becomes 8
    issue(3'd1, 8'd4, 8'd4, 1'b0, 0);
    check("addnord_rsp_cycle", 64'(rsp_cyc), 64'd5);
    check("addnord_data", {got_err, got_data}, 9'd0);

    // NONE with read returns the device result
    issue(3'd0, 8'd0, 8'd0, 1'b1, 0);
    check("noneread_rsp_cycle", 64'(rsp_cyc), 64'd3);
    check("noneread_data", 64'(got_data), 64'h08);
    check("noneread_cs_din", {cs_mask[7:0], din_log[1]}, {8'h02, 8'h20});

    // Device busy for 4 cycles before CMD2: everything shifts by 4
    issue(3'd1, 8'd5, 8'd3, 1'b1, 5);
    check("busy_rsp_cycle", 64'(rsp_cyc), 64'd12);
    check("busy_cs_cycles", cs_mask, 64'h4A0);
    check("busy_data", {got_err, got_data}, {1'b0, 8'h08});

    // Device never raises drdy: abort after 16 cycles in WAIT_DRDY
    mute_drdy = 1'b1;
    issue(3'd0, 8'd0, 8'd0, 1'b1, 0);
    mute_drdy = 1'b0;
    check("tmo_rsp_cycle", 64'(rsp_cyc), 64'd18);
    check("tmo_err_data", {got_err, got_data}, {1'b1, 8'h00});
    check("tmo_ready_after", 64'(ready_after), 64'd1);

    // Reset during DAT1, then a clean ADD
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd1; req_a = 8'd9; req_b = 8'd9; req_rd = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    #1;
    check("rst_pre_dat1_din", 64'(dev_din), 64'h09);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("rst_abort_outputs", {dev_cs, dev_din, rsp_valid, req_ready, rsp_err},
          {1'b0, 8'h00, 1'b0, 1'b1, 1'b0});
    rst = 1'b1;
    issue(3'd1, 8'd1, 8'd2, 1'b1, 0);
    check("post_rst_rsp_cycle", 64'(rsp_cyc), 64'd8);
    check("post_rst_data", {got_err, got_data}, {1'b0, 8'h03});

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/calc_host.md
Name: calc_host

Overview:
- Bus initiator for the calculator device protocol (cs / din / busy / drdy / dout).
- Accepts one arithmetic request at a time over a valid/ready interface and converts it into the device command/operand byte sequence.
- When a read is requested, waits for drdy, captures the device result and returns it as a one-cycle response pulse.
- Sits between the system-side controller and the calculator device; one host per device.

Parameters:
DW, 8, data width of operands, command byte and result.
TMO, 16, cycles the host waits on dev_busy low or dev_drdy high before aborting with an error.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
req_valid  in  1  request present
req_ready  out  1  host can accept a request
req_op  in  3  op_e: OP_NONE=0, OP_ADD=1 (a+b), OP_SUB=2 (a-b), OP_ACC_ADD=3 (res+a), OP_ACC_SUB=4 (res-a)
req_a  in  DW  operand 1
req_b  in  DW  operand 2; used only by OP_ADD/OP_SUB
req_rd  in  1  read the device result after the operation
rsp_valid  out  1  one-cycle completion pulse
rsp_data  out  DW  captured result; 0 if no read or on error
rsp_err  out  1  timeout abort, valid with rsp_valid
dev_cs  out  1  device chip select
dev_din  out  DW  byte driven to the device
dev_busy  in  1  device not idle
dev_drdy  in  1  device result valid on dev_dout
dev_dout  in  DW  device result

Behaviour:
- Reset values: state IDLE; req_ready=1; rsp_valid=0; rsp_data=0; rsp_err=0; dev_cs=0; dev_din=0; latched request and timeout counter cleared. Reset mid-sequence aborts immediately with no response.
- Handshake: accept when req_valid && req_ready. Latch op, a, b, rd. req_ready = (state==IDLE). Inputs are ignored while not ready.
- Command bytes use the cmd_bits constants:
  - CMD_OP2 = only b_op_2 set.
  - CMD_ALU = only the opcode bit set: b_addop for ADD, b_subop for SUB, b_addres for ACC_ADD, b_subres for ACC_SUB.
  - CMD_RD = only b_tx set.
- States and transitions:
  - IDLE: on accept → CMD2 if ADD/SUB; else CMD1 if op≠NONE; else CMD_RD if rd; else DONE.
  - CMD2: dev_cs=1 and dev_din=CMD_OP2, only in a cycle where dev_busy=0; then → DAT2. While busy=1, dev_cs=0 and the state holds.
  - DAT2: dev_cs=0, dev_din=b → CMD1.
  - CMD1: same busy gating, dev_din=CMD_ALU → DAT1.
  - DAT1: dev_din=a → CMD_RD if rd, else DONE.
  - CMD_RD: same busy gating, dev_din=CMD_RD → WAIT_DRDY.
  - WAIT_DRDY: when dev_drdy=1, rsp_data<=dev_dout → DONE.
  - DONE: rsp_valid=1 for exactly one cycle → IDLE.
- Output gating: dev_cs = (state ∈ {CMD2, CMD1, CMD_RD}) && !dev_busy. This is a combinational path from dev_busy. dev_din=0 in all other states.
- Timeout: counter resets on every state change and increments while in a CMD* or WAIT_DRDY state. On reaching TMO-1 without progress → DONE with rsp_err=1, rsp_data=0, dev_cs=0.
- Latency with an immediately ready device (cycle 0 = accept cycle): rsp_valid is high in
  - cycle 8 for ADD/SUB with read;
  - cycle 5 for ADD/SUB without read;
  - cycle 6 for ACC_* with read;
  - cycle 3 for NONE with read;
  - cycle 1 for NONE without read.
  In the read cases the host waits one cycle in CMD_RD while the device is in its process cycle.
- Arithmetic is performed by the device, modulo 2^DW; the host never modifies data.
- Simultaneous events:
  - dev_drdy outside WAIT_DRDY is ignored.
  - dev_busy=1 and timeout expiry in the same cycle: timeout wins.
  - A new request presented in the DONE cycle is not accepted until IDLE.

Decomposition:
- cmd_bits package: existing bit constants plus new op_e typedef and CMD_OP2/CMD_RD helper constants, plus a function op_to_cmd(op_e) → DW-bit command byte.
- One sub-module, calc_host_tmo: loadable timeout counter with TMO parameter, clear input and expired output.

Test Plan:
- ADD a=5, b=3, rd=1 against the real device → dev_cs high in cycles 1, 3, 6; dev_din sequence CMD_OP2, 3, CMD_ALU(add), 5, CMD_RD; rsp_valid in cycle 8 with rsp_data=8, rsp_err=0.
- SUB a=2, b=7, rd=1 → rsp_data=8'hFB (wrap-around); then ACC_ADD a=10, rd=1 → rsp_data=8'h05 in cycle 6.
- NONE, rd=0 → rsp_valid in cycle 1, rsp_data=0, no dev_cs pulse; NONE, rd=1 → rsp_data equals the previous result in cycle 3.
- Device model holding dev_busy=1 for 4 cycles before CMD2 → dev_cs stays 0 until busy falls; the whole sequence shifts by 4 cycles; result is unchanged.
- Device model never asserting dev_drdy, TMO=16 → rsp_valid with rsp_err=1, rsp_data=0 after 16 cycles in WAIT_DRDY; req_ready=1 the cycle after.
- rst pulled low during DAT1 → next cycle dev_cs=0, dev_din=0, rsp_valid=0, req_ready=1; after release, a new ADD completes normally.
